irq_timer: RTL

- Memory-mapped timer and interrupt-request block sitting directly upstream of the PC-update stage.
- Counts TL up from a reloadable TH value.
- On TL wrap it raises IRQ; the control unit then selects PCSrc = ILLOP, so the next PC is 0x80000004.
- Captures the interrupted PC into EPC so the handler can return through the DataBusA path.

---
 rtl/irq_timer.sv | 61 ++++++
 1 files changed

// File: rtl/irq_timer.sv
// irq_timer: memory-mapped reloadable timer with interrupt request and exception PC capture
module irq_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  input  logic        TakeIRQ,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        IRQ,
  output logic [31:0] EPC
);
  logic [31:0] th, tl, epc_q, tick;
  logic        en, ie, st;
  logic        hit, ovf, wr_th, wr_tl, wr_tcon, wr_epc;
  logic [2:0]  off;
  assign hit     = Addr[31:5] == BASE_ADDR[31:5] && Addr[1:0] == 2'b00;
  assign off     = Addr[4:2];
  assign wr_th   = MemWrite && hit && off == 3'd0;
  assign wr_tl   = MemWrite && hit && off == 3'd1;
  assign wr_tcon = MemWrite && hit && off == 3'd2;
  assign wr_epc  = MemWrite && hit && off == 3'd3;
  assign ovf     = en && &tl;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th    <= '0;
      tl    <= '0;
      en    <= 1'b0;
      ie    <= 1'b0;
      st    <= 1'b0;
      epc_q <= '0;
      tick  <= '0;
    end else begin
      tick <= tick + 32'd1;
      if (wr_th) th <= WriteData;
      if (wr_tl) tl <= WriteData;
      else if (en) tl <= ovf ? th : tl + 32'd1;
      if (wr_tcon) begin
        en <= WriteData[0];
        ie <= WriteData[1];
      end
      // a hardware overflow set always beats a software clear
      st <= (wr_tcon ? WriteData[2] : st) | (ovf & ie);
      if (TakeIRQ) epc_q <= PC;
      else if (wr_epc) epc_q <= WriteData;
    end
  end
  always_comb
    ReadData = !(MemRead && hit) ? 32'd0 :
               off == 3'd0 ? th :
               off == 3'd1 ? tl :
               off == 3'd2 ? {29'd0, st, ie, en} :
               off == 3'd3 ? epc_q :
               off == 3'd4 ? tick : 32'd0;
  assign IRQ = st & ie & ~PC[31];
  assign EPC = epc_q;
endmodule
